// File: rtl/jtframe_db15_joy.sv
// DB15 adapter reader: clocks a 24-bit 74HC165 chain and turns each scan into two active-high player words.
// Latency: one frame of (GAP+50)*CLK_DIV+1 clocks per commit. No backpressure: joy_valid is a one-cycle pulse.
// Optional JTFRAME_DB15_DEBOUNCE_EN: commit only when two consecutive scans read identical raw data.
module jtframe_db15_joy #(
    parameter int CLK_DIV = 48,
    parameter int GAP     = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  mode,
    input  logic        joy_data,
    output logic        joy_clk,
    output logic        joy_load,
    output logic [11:0] joy1,
    output logic [11:0] joy2,
    output logic        joy_valid
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = $clog2(GAP + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [1:0]       state;
    logic [GAP_W-1:0] gap_cnt;
    logic             load_cnt;
    logic             phase;
    logic [4:0]       k;
    logic [23:0]      raw;
    logic             commit_ok;

`ifdef JTFRAME_DB15_DEBOUNCE_EN
    logic [23:0] prev_raw;

    always_comb begin
        commit_ok = (raw == prev_raw);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || mode == 2'd0) begin
            prev_raw <= '0;
        end else if (state == ST_DONE) begin
            prev_raw <= raw;
        end
    end
`else
    always_comb begin
        commit_ok = 1'b1;
    end
`endif

    always_comb begin
        tick = (cnt == CNT_W'(CLK_DIV - 1));
    end

    // Tick counter is frozen during DONE, which is what makes a frame one clock longer than a tick multiple.
    always_ff @(posedge clk) begin
        if (!rst_n || mode == 2'd0) begin
            cnt <= '0;
        end else if (state != ST_DONE) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || mode == 2'd0) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            load_cnt  <= 1'b0;
            phase     <= 1'b0;
            k         <= '0;
            joy_clk   <= 1'b1;
            joy_load  <= 1'b1;
            joy1      <= '0;
            joy2      <= '0;
            joy_valid <= 1'b0;
            if (!rst_n) begin
                raw <= '0;
            end
        end else begin
            joy_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        if (gap_cnt == GAP_W'(GAP - 1)) begin
                            gap_cnt  <= '0;
                            load_cnt <= 1'b0;
                            joy_load <= 1'b0;
                            state    <= ST_LOAD;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (tick) begin
                        if (load_cnt) begin
                            joy_load <= 1'b1;
                            k        <= '0;
                            phase    <= 1'b0;
                            state    <= ST_SHIFT;
                        end else begin
                            load_cnt <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            joy_clk <= 1'b0;
                            phase   <= 1'b1;
                        end else begin
                            // Sample on the edge that raises joy_clk; the adapter shifts on that rise.
                            raw[k]  <= joy_data;
                            joy_clk <= 1'b1;
                            phase   <= 1'b0;
                            k       <= k + 5'd1;
                            if (k == 5'd23) begin
                                state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (commit_ok) begin
                        joy1      <= ~raw[11:0];
                        joy2      <= (mode == 2'd1) ? 12'd0 : ~raw[23:12];
                        joy_valid <= 1'b1;
                    end
                    gap_cnt <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
